spectro_capture: RTL and testbench

SPECTRO_CAPTURE -- requirements
Module: spectro_capture

---
 rtl/spectro_pkg.sv | 23 ++
 rtl/spectro_fifo.sv | 53 +++++
 rtl/spectro_capture.sv | 136 +++++++++++++
 tb/tb_spectro_capture.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spectro_pkg.sv
// rtl/spectro_pkg.sv - shared types, default sizes and width helpers for spectro_capture
package spectro_pkg;

  typedef enum logic [1:0] {
    ST_ACQ  = 2'd0,
    ST_FULL = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CH_W   = 7;
  localparam int DEF_TS_W   = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int rec_w(input int ts_w, input int num_ch);
    return ts_w + num_ch;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/spectro_fifo.sv
// rtl/spectro_fifo.sv - synchronous first-word-fall-through record FIFO
// nxt_data exposes the entry behind the head so a pop can reload a consumer in the same edge.
module spectro_fifo #(
  parameter int W     = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr,
  input  logic [W-1:0]               wr_data,
  input  logic                       rd,
  output logic [W-1:0]               rd_data,
  output logic [W-1:0]               nxt_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr_ok;
  logic          rd_ok;

  assign full     = (count == CW'(DEPTH));
  assign wr_ok    = wr && !full;
  assign rd_ok    = rd && (count != '0);
  assign rd_data  = mem[rptr];
  assign nxt_data = mem[rptr + 1'b1];

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spectro_capture.sv
// rtl/spectro_capture.sv - threshold-crossing event recorder with timestamped serial dump
// Rising crossings per channel are stored as {ts, mask} and shifted out MSB first on ser_tick.
module spectro_capture
  import spectro_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CH_W   = DEF_CH_W,
  parameter int TS_W   = DEF_TS_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acq_en,
  input  logic                       rtc_tick,
  input  logic                       ser_tick,
  input  logic                       readout_req,
  input  logic [CH_W-1:0]            thr,
  input  logic [NUM_CH*CH_W-1:0]     ch_in,
  output logic                       serial_out,
  output logic                       sl_time,
  output logic                       sl_ch,
  output logic                       signal_detected,
  output logic                       mem_full,
  output logic                       sending_data,
  output logic                       overflow,
  output logic [cnt_w(DEPTH)-1:0]    fifo_count
);

  localparam int REC_W = rec_w(TS_W, NUM_CH);
  localparam int CNT_W = cnt_w(DEPTH);
  localparam int BW    = $clog2(REC_W);

  state_t            state;
  logic [TS_W-1:0]   ts;
  logic [NUM_CH-1:0] prev;
  logic [NUM_CH-1:0] above;
  logic [NUM_CH-1:0] mask;
  logic [REC_W-1:0]  shreg;
  logic [BW-1:0]     bit_cnt;
  logic [REC_W-1:0]  head;
  logic [REC_W-1:0]  nxt;
  logic              fifo_full;
  logic              hit;
  logic              wr;
  logic              rd;
  logic              last_bit;
  logic              last_pop;

  always_comb begin
    above = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      above[k] = (ch_in[k*CH_W +: CH_W] >= thr);
    end
  end

  assign mask     = acq_en ? (above & ~prev) : '0;
  assign hit      = |mask;
  assign wr       = hit && (state == ST_ACQ) && !fifo_full;
  assign last_bit = (bit_cnt == BW'(REC_W - 1));
  assign rd       = (state == ST_SEND) && ser_tick && last_bit;
  assign last_pop = rd && (fifo_count == CNT_W'(1));

  spectro_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr),
    .wr_data  ({ts, mask}),
    .rd       (rd),
    .rd_data  (head),
    .nxt_data (nxt),
    .count    (fifo_count),
    .full     (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_ACQ;
      ts              <= '0;
      prev            <= '0;
      shreg           <= '0;
      bit_cnt         <= '0;
      signal_detected <= 1'b0;
      overflow        <= 1'b0;
    end else begin
      if (rtc_tick) ts <= ts + 1'b1;
      if (acq_en) prev <= above;
      signal_detected <= wr;
      // A drop in the same cycle as the final pop keeps the sticky flag set.
      if (hit && !wr) overflow <= 1'b1;
      else if (last_pop) overflow <= 1'b0;

      case (state)
        ST_ACQ: begin
          if (wr) begin
            if (fifo_count == CNT_W'(DEPTH - 1)) state <= ST_FULL;
          end else if (readout_req && fifo_count != '0) begin
            state   <= ST_SEND;
            shreg   <= head;
            bit_cnt <= '0;
          end
        end
        ST_FULL: begin
          if (readout_req) begin
            state   <= ST_SEND;
            shreg   <= head;
            bit_cnt <= '0;
          end
        end
        ST_SEND: begin
          if (ser_tick) begin
            if (!last_bit) begin
              shreg   <= {shreg[REC_W-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end else begin
              bit_cnt <= '0;
              if (last_pop) begin
                state <= ST_ACQ;
                shreg <= '0;
              end else begin
                shreg <= nxt;
              end
            end
          end
        end
        default: state <= ST_ACQ;
      endcase
    end
  end

  assign sending_data = (state == ST_SEND);
  assign mem_full     = (state == ST_FULL);
  assign serial_out   = sending_data && shreg[REC_W-1];
  assign sl_time      = sending_data && (bit_cnt < BW'(TS_W));
  assign sl_ch        = sending_data && (bit_cnt >= BW'(TS_W));

endmodule

// File: tb/tb_spectro_capture.sv
// tb/tb_spectro_capture.sv - randomized and directed bench for spectro_capture
// Reference model: a queue of {ts,mask} records plus dump position, updated per clock edge.
module tb_spectro_capture;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 7;
  localparam int TS_W   = 8;
  localparam int DEPTH  = 4;
  localparam int REC_W  = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acq_en = 1'b0;
  logic        rtc_tick = 1'b0;
  logic        ser_tick = 1'b0;
  logic        readout_req = 1'b0;
  logic [6:0]  thr = 7'd64;
  logic [27:0] ch_in = '0;
  logic        serial_out, sl_time, sl_ch, signal_detected;
  logic        mem_full, sending_data, overflow;
  logic [2:0]  fifo_count;

  always #5 clk = ~clk;

  spectro_capture #(.NUM_CH(NUM_CH), .CH_W(CH_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .acq_en          (acq_en),
    .rtc_tick        (rtc_tick),
    .ser_tick        (ser_tick),
    .readout_req     (readout_req),
    .thr             (thr),
    .ch_in           (ch_in),
    .serial_out      (serial_out),
    .sl_time         (sl_time),
    .sl_ch           (sl_ch),
    .signal_detected (signal_detected),
    .mem_full        (mem_full),
    .sending_data    (sending_data),
    .overflow        (overflow),
    .fifo_count      (fifo_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [11:0] q[$];
  logic [11:0] got[$];
  int          m_ts = 0;
  int          m_pos = 0;
  logic [3:0]  m_prev = '0;
  bit          m_ovf = 0;
  bit          m_send = 0;
  bit          m_det = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [27:0] pack(input int a0, input int a1, input int a2, input int a3);
    return {7'(a3), 7'(a2), 7'(a1), 7'(a0)};
  endfunction

  task automatic model_edge(input bit acq, input bit rtc, input bit ser, input bit req,
                            input logic [27:0] chv);
    logic [3:0] above;
    logic [3:0] mask;
    bit         wrote;
    if (!rst_n) begin
      q.delete();
      m_ts = 0; m_pos = 0; m_prev = '0; m_ovf = 0; m_send = 0; m_det = 0;
      return;
    end
    wrote = 0;
    if (acq) begin
      for (int k = 0; k < NUM_CH; k++) above[k] = (chv[k*CH_W +: CH_W] >= thr);
      mask = above & ~m_prev;
      m_prev = above;
      if (mask != 0) begin
        if (!m_send && q.size() < DEPTH) begin
          q.push_back({8'(m_ts), mask});
          wrote = 1;
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (m_send) begin
      if (ser) begin
        if (m_pos < REC_W - 1) m_pos++;
        else begin
          q.delete(0);
          m_pos = 0;
          if (q.size() == 0) begin m_send = 0; m_ovf = 0; end
        end
      end
    end else if (req && !wrote && q.size() > 0) begin
      m_send = 1;
      m_pos = 0;
    end
    if (rtc) m_ts = (m_ts + 1) % 256;
    m_det = wrote;
  endtask

  task automatic compare();
    logic [11:0] h;
    bit          exp_bit;
    exp_bit = 0;
    if (m_send && q.size() > 0) begin
      h = q[0];
      exp_bit = h[REC_W-1-m_pos];
    end
    chk("signal_detected", signal_detected, m_det);
    chk("fifo_count", fifo_count, q.size());
    chk("overflow", overflow, m_ovf);
    chk("sending_data", sending_data, m_send);
    chk("mem_full", mem_full, !m_send && q.size() == DEPTH);
    chk("serial_out", serial_out, exp_bit);
    chk("sl_time", sl_time, m_send && m_pos < TS_W);
    chk("sl_ch", sl_ch, m_send && m_pos >= TS_W);
  endtask

  task automatic step(input bit acq, input bit rtc, input bit ser, input bit req,
                      input logic [27:0] chv);
    acq_en = acq; rtc_tick = rtc; ser_tick = ser; readout_req = req; ch_in = chv;
    @(posedge clk);
    model_edge(acq, rtc, ser, req, chv);
    @(negedge clk);
    compare();
  endtask

  task automatic hit(input logic [27:0] chv);
    step(1, 0, 0, 0, chv);
  endtask

  task automatic tick_to(input int target);
    while (m_ts != target) step(0, 1, 0, 0, ch_in);
  endtask

  task automatic readout();
    logic [11:0] cur;
    int          bits;
    int          guard;
    cur = '0; bits = 0; guard = 0;
    got.delete();
    step(0, 0, 0, 1, ch_in);
    while (m_send && guard < 1000) begin
      cur = {cur[10:0], serial_out};
      bits++;
      if (bits == REC_W) begin got.push_back(cur); bits = 0; end
      step(0, 0, 1, 0, ch_in);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) step(0, 0, 0, 0, ch_in);
      guard++;
    end
    if (guard >= 1000) chk("dump_timeout", 1, 0);
  endtask

  initial begin
    logic [11:0] r;
    @(negedge clk);
    rst_n = 0;
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    rst_n = 1;

    thr = 7'd64;
    hit('0);
    tick_to(5);
    hit(pack(0, 0, 70, 0));
    chk("r41_det", signal_detected, 1);
    chk("r41_cnt", fifo_count, 1);
    step(0, 0, 0, 0, ch_in);
    chk("r41_pulse", signal_detected, 0);
    hit(pack(0, 0, 70, 0));
    hit(pack(0, 0, 70, 0));
    chk("r42_hold", fifo_count, 1);
    tick_to(9);
    hit(pack(100, 0, 70, 100));
    chk("r42_cnt", fifo_count, 2);
    readout();
    chk("r42_dump_n", got.size(), 2);
    if (got.size() == 2) begin
      chk("r41_rec", got[0], 12'h054);
      chk("r42_rec", got[1], 12'h099);
    end

    hit('0);
    for (int i = 0; i < 5; i++) begin
      hit(pack(100, 0, 0, 0));
      hit('0);
      if (i == 3) chk("r43_full", mem_full, 1);
    end
    chk("r43_ovf", overflow, 1);
    chk("r43_cnt", fifo_count, 4);
    readout();
    chk("r43_dump_n", got.size(), 4);
    chk("r43_ovf_clr", overflow, 0);

    tick_to(8'hA5);
    hit(pack(100, 100, 0, 0));
    readout();
    chk("r44_dump_n", got.size(), 1);
    if (got.size() == 1) chk("r44_rec", got[0], 12'hA53);
    chk("r44_acq", sending_data, 0);
    chk("r44_ovf", overflow, 0);

    hit('0);
    hit(pack(100, 0, 0, 0));
    step(0, 0, 0, 1, ch_in);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, ch_in);
    rst_n = 0;
    step(0, 0, 0, 0, ch_in);
    rst_n = 1;
    chk("r45_cnt", fifo_count, 0);
    chk("r45_send", sending_data, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, ch_in);
    chk("r45_sout", serial_out, 0);

    tick_to(255);
    step(0, 1, 0, 0, ch_in);
    hit('0);
    hit(pack(0, 100, 0, 0));
    readout();
    chk("r46_dump_n", got.size(), 1);
    if (got.size() == 1) begin
      r = got[0];
      chk("r46_ts", r[11:4], 0);
    end

    for (int c = 0; c < 4000; c++) begin
      bit a, s;
      if (c % 250 == 0) thr = 7'($urandom);
      a = ($urandom_range(0, 2) == 0);
      s = !a && ($urandom_range(0, 1) == 1);
      step(a, $urandom_range(0, 3) == 0, s, $urandom_range(0, 11) == 0, 28'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
